// File: rtl/fft_bit_reverse_stream_if.sv
// fft_bit_reverse_stream_if: recv/send val-rdy stream bundle for the bit-reversal reorder buffer
interface fft_bit_reverse_stream_if #(parameter int BIT_WIDTH = 32);
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_bypass;
  logic                 send_val;
  logic                 send_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic                 send_last;
  modport slave (
    input  recv_val, recv_msg, recv_bypass, send_rdy,
    output recv_rdy, send_val, send_msg, send_last
  );
  modport master (
    output recv_val, recv_msg, recv_bypass, send_rdy,
    input  recv_rdy, send_val, send_msg, send_last
  );
endinterface

// File: rtl/fft_bit_reverse_stream.sv
// fft_bit_reverse_stream: ping-pong frame buffer emitting natural-order input in bit-reversed (or bypass natural) order
module fft_bit_reverse_stream #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input logic                      clk,
  input logic                      reset,
  fft_bit_reverse_stream_if.slave  io
);
  localparam int N = $clog2(N_SAMPLES);
  localparam logic [N-1:0] last_idx = N'(N_SAMPLES - 1);
  logic [BIT_WIDTH-1:0] mem [2][N_SAMPLES];
  logic [1:0]           full;
  logic [1:0]           bypass;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [N-1:0]         wr_idx;
  logic [N-1:0]         rd_idx;
  logic [N-1:0]         rev_idx;
  logic [N-1:0]         rd_addr;
  logic                 recv_fire;
  logic                 send_fire;
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign rev_idx[i] = rd_idx[N-1-i];
  end
  always_comb begin
    io.recv_rdy  = !full[wr_bank];
    io.send_val  = full[rd_bank];
    io.send_last = full[rd_bank] && (rd_idx == last_idx);
    rd_addr      = bypass[rd_bank] ? rd_idx : rev_idx;
    io.send_msg  = mem[rd_bank][rd_addr];
    recv_fire    = io.recv_val && !full[wr_bank];
    send_fire    = io.send_rdy && full[rd_bank];
  end
  always_ff @(posedge clk)
    if (recv_fire) mem[wr_bank][wr_idx] <= io.recv_msg;
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= '0;
      bypass  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else begin
      if (recv_fire) begin
        if (wr_idx == '0) bypass[wr_bank] <= io.recv_bypass;
        if (wr_idx == last_idx) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
        wr_idx <= wr_idx + N'(1);
      end
      if (send_fire) begin
        if (rd_idx == last_idx) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
        rd_idx <= rd_idx + N'(1);
      end
    end
  end
endmodule

// File: tb/tb_fft_bit_reverse_stream.sv
// tb_fft_bit_reverse_stream: directed and random self-checking bench for the bit-reversal stream buffer
module tb_fft_bit_reverse_stream;
  localparam int W = 32;
  localparam int N = 8;
  typedef struct {
    logic [W-1:0] msg;
    logic         byp;
    logic [W-1:0] exp;
    logic         last;
  } vec_t;
  typedef struct {
    logic [W-1:0] msg;
    logic         last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  exp_t exp_q [$];
  int   out_cyc [$];
  int   applied = 0;
  int   miscompares = 0;
  int   last_in_cyc = 0;
  int   stalls = 0;
  fft_bit_reverse_stream_if #(.BIT_WIDTH(W)) ifc ();
  fft_bit_reverse_stream #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (.clk(clk), .reset(reset), .io(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int rev(int i);
    return {i[0], i[1], i[2]};
  endfunction
  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && ifc.send_val && ifc.send_rdy) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_output", ifc.send_val, 1'b0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("send_msg", ifc.send_msg, e.msg);
          check("send_last", ifc.send_last, e.last);
        end
      end
    end
  endtask
  task automatic push_frame(logic [W-1:0] base, logic byp);
    for (int j = 0; j < N; j++) begin
      exp_t e;
      e.msg  = base + W'(byp ? j : rev(j));
      e.last = (j == N - 1);
      exp_q.push_back(e);
    end
  endtask
  task automatic feed(logic [W-1:0] m, logic b);
    int w;
    w = 0;
    ifc.recv_val    = 1'b1;
    ifc.recv_msg    = m;
    ifc.recv_bypass = b;
    forever begin
      @(negedge clk);
      if (ifc.recv_rdy) break;
      stalls++;
      w++;
      if (w > 300) begin
        check("recv_timeout", ifc.recv_rdy, 1'b1);
        break;
      end
      @(posedge clk);
      #1;
    end
    last_in_cyc = cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check("drain_done", exp_q.size(), 0);
  endtask
  initial begin
    vec_t         tbl [16];
    int           e1 [8] = '{10, 14, 12, 16, 11, 15, 13, 17};
    int           base;
    int           in7;
    int           acc;
    int           frames_in;
    int           idx;
    logic         byp_f;
    logic [W-1:0] fv [8];
    for (int i = 0; i < 8; i++) begin
      tbl[i].msg     = W'(10 + i);
      tbl[i].byp     = 1'b0;
      tbl[i].exp     = W'(e1[i]);
      tbl[i].last    = (i == 7);
      tbl[8+i].msg   = W'(20 + i);
      tbl[8+i].byp   = (i == 0);
      tbl[8+i].exp   = W'(20 + i);
      tbl[8+i].last  = (i == 7);
    end
    ifc.recv_val    = 1'b0;
    ifc.recv_msg    = '0;
    ifc.recv_bypass = 1'b0;
    ifc.send_rdy    = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_recv_rdy", ifc.recv_rdy, 1'b1);
    check("reset_send_val", ifc.send_val, 1'b0);
    check("reset_send_last", ifc.send_last, 1'b0);
    reset = 1'b0;
    ifc.send_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("idle_send_val", ifc.send_val, 1'b0);
    base = out_cyc.size();
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.msg  = tbl[i].exp;
      e.last = tbl[i].last;
      exp_q.push_back(e);
      feed(tbl[i].msg, tbl[i].byp);
      if (i == 7) in7 = last_in_cyc;
    end
    ifc.recv_val = 1'b0;
    drain();
    check("first_latency", out_cyc[base], in7 + 1);
    stalls = 0;
    base = out_cyc.size();
    for (int f = 0; f < 3; f++) push_frame(W'(f * 8), 1'b0);
    for (int i = 0; i < 24; i++) begin
      feed(W'(i), 1'b0);
      if (i == 7) in7 = last_in_cyc;
    end
    ifc.recv_val = 1'b0;
    drain();
    check("stream_no_stall", stalls, 0);
    check("stream_first_out", out_cyc[base], in7 + 1);
    check("stream_contiguous", out_cyc[base+23] - out_cyc[base], 23);
    ifc.send_rdy = 1'b0;
    for (int f = 0; f < 3; f++) push_frame(W'(100 + f * 8), 1'b0);
    acc = 0;
    ifc.recv_val = 1'b1;
    ifc.recv_bypass = 1'b0;
    for (int c = 0; c < 30 && acc < 24; c++) begin
      ifc.recv_msg = W'(100 + acc);
      @(negedge clk);
      if (ifc.recv_rdy) acc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts", acc, 16);
    check("bp_recv_rdy", ifc.recv_rdy, 1'b0);
    check("bp_send_val", ifc.send_val, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_msg", ifc.send_msg, 100);
      check("bp_hold_last", ifc.send_last, 1'b0);
    end
    @(posedge clk);
    #1;
    ifc.send_rdy = 1'b1;
    while (acc < 24) begin
      feed(W'(100 + acc), 1'b0);
      acc++;
    end
    ifc.recv_val = 1'b0;
    drain();
    check("bp_rdy_after_drain", ifc.recv_rdy, 1'b1);
    frames_in = 0;
    idx = 0;
    byp_f = 1'b0;
    for (int c = 0; c < 8000 && !(frames_in == 50 && exp_q.size() == 0); c++) begin
      ifc.send_rdy    = $urandom_range(0, 1) == 1;
      ifc.recv_val    = (frames_in < 50) && ($urandom_range(0, 1) == 1);
      ifc.recv_msg    = $urandom;
      ifc.recv_bypass = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (ifc.recv_val && ifc.recv_rdy) begin
        if (idx == 0) byp_f = ifc.recv_bypass;
        fv[idx] = ifc.recv_msg;
        if (idx == 7) begin
          for (int j = 0; j < N; j++) begin
            exp_t e;
            e.msg  = fv[byp_f ? j : rev(j)];
            e.last = (j == N - 1);
            exp_q.push_back(e);
          end
          frames_in++;
          idx = 0;
        end else idx++;
      end
      @(posedge clk);
      #1;
    end
    ifc.recv_val = 1'b0;
    ifc.send_rdy = 1'b1;
    check("rand_frames", frames_in, 50);
    check("rand_drained", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) feed(W'(200 + i), 1'b0);
    ifc.recv_val = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst1_send_val", ifc.send_val, 1'b0);
    check("rst1_recv_rdy", ifc.recv_rdy, 1'b1);
    @(posedge clk);
    #1;
    push_frame(W'(300), 1'b0);
    push_frame(W'(308), 1'b0);
    for (int i = 0; i < 16; i++) feed(W'(300 + i), 1'b0);
    ifc.recv_val = 1'b0;
    for (int c = 0; c < 50 && exp_q.size() > 5; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst2_mid_drain", exp_q.size(), 5);
    ifc.send_rdy = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifc.send_rdy = 1'b1;
    @(negedge clk);
    check("rst2_send_val", ifc.send_val, 1'b0);
    check("rst2_recv_rdy", ifc.recv_rdy, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.msg  = tbl[i].exp;
      e.last = tbl[i].last;
      exp_q.push_back(e);
      feed(tbl[i].msg, tbl[i].byp);
    end
    ifc.recv_val = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
